// File: rtl/bancoreg_loader.sv
// bancoreg_loader
// Drives the Bancoreg register bank from board switches and buttons.
// Both buttons go through a 2-flop synchronizer and a saturating stability
// counter. A press gives a one-cycle pulse.
//
// Modes:
//   FILL  : waits for a button pulse.
//   WRITE : one cycle that writes sw to the auto-incrementing address wptr.
//   SCAN  : steps the read-address pairs (rptr, 7-rptr) every SCAN_CYCLES.
//   CLR   : writes zero to addresses 0..7 on eight consecutive cycles.
//
// Ports:
//   clk, rst(async, active-low)   clock / reset
//   sw[3:0]                       data switches
//   btn_wr, btn_mode              raw bouncy push-buttons
//   addrW[2:0], datW[3:0]         bank write address / data
//   RegWrite                      bank write enable (registered)
//   addrRa[2:0], addrRb[2:0]      bank read addresses
//   mode[1:0]                     FSM state (00 FILL, 01 WRITE, 10 SCAN, 11 CLR)
//   full                          address 7 written since reset/clear
//
// Handshake: the bank has no ready signal. A write is taken on every rising
// edge where RegWrite=1. addrW and datW are stable for that whole cycle.
module bancoreg_loader #(
  parameter int DB_CYCLES   = 250000,
  parameter int SCAN_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic       btn_wr,
  input  logic       btn_mode,
  output logic [2:0] addrW,
  output logic [3:0] datW,
  output logic       RegWrite,
  output logic [2:0] addrRa,
  output logic [2:0] addrRb,
  output logic [1:0] mode,
  output logic       full
);

  localparam int DBW = $clog2(DB_CYCLES) + 1;
  localparam int DWW = $clog2(SCAN_CYCLES) + 1;
  localparam logic [DBW-1:0] DB_MAX     = DBW'(DB_CYCLES);
  localparam logic [DBW-1:0] DB_ONE     = DBW'(1);
  localparam logic [DWW-1:0] DWELL_LAST = DWW'(SCAN_CYCLES - 1);
  localparam logic [DWW-1:0] DWELL_ONE  = DWW'(1);

  typedef enum logic [1:0] {
    FILL  = 2'b00,
    WRITE = 2'b01,
    SCAN  = 2'b10,
    CLR   = 2'b11
  } state_t;

  state_t state, state_n;

  // Button conditioning. Index 0 is the write button and index 1 is the
  // mode button.
  logic [1:0]     raw, sync1, sync2, deb, deb_q, pulse;
  logic [DBW-1:0] db_cnt [2];
  logic           wr_p, mode_p;

  assign raw = {btn_mode, btn_wr};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb_q <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
      for (int i = 0; i < 2; i++) begin
        if (!sync2[i])
          db_cnt[i] <= '0;
        else if (db_cnt[i] != DB_MAX)
          db_cnt[i] <= db_cnt[i] + DB_ONE;
      end
    end
  end

  always_comb begin
    deb = '0;
    for (int i = 0; i < 2; i++) deb[i] = (db_cnt[i] == DB_MAX);
    pulse = deb & ~deb_q;
  end

  assign wr_p   = pulse[0];
  assign mode_p = pulse[1];

  // Datapath state.
  logic [2:0]     wptr, cptr;
  logic [1:0]     rptr, rptr_n;
  logic [DWW-1:0] dwell;
  logic           scan_step;

  // FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FILL;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      FILL:  if (wr_p)           state_n = WRITE;  // wr_p wins over mode_p
             else if (mode_p)    state_n = SCAN;
      WRITE:                     state_n = FILL;
      SCAN:  if (mode_p)         state_n = CLR;
      CLR:   if (cptr == 3'd7)   state_n = FILL;
      default:                   state_n = FILL;
    endcase
  end

  assign scan_step = (state == SCAN) && (dwell == DWELL_LAST);
  assign rptr_n    = scan_step ? rptr + 2'd1 : rptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr     <= '0;
      rptr     <= '0;
      cptr     <= '0;
      dwell    <= '0;
      full     <= 1'b0;
      datW     <= '0;
      RegWrite <= 1'b0;
      addrRa   <= 3'd0;
      addrRb   <= 3'd7;
    end else begin
      RegWrite <= (state_n == WRITE) || (state_n == CLR);

      // The dwell counter restarts on every entry to SCAN. rptr itself
      // persists, so a resumed scan continues from where it left off.
      if (state == SCAN)
        dwell <= scan_step ? '0 : dwell + DWELL_ONE;
      else
        dwell <= '0;
      rptr <= rptr_n;

      // The read addresses follow the pointer only while in SCAN. Using
      // rptr_n makes the outputs change on the same edge as the pointer.
      if (state_n == SCAN) begin
        addrRa <= {1'b0, rptr_n};
        addrRb <= 3'd7 - {1'b0, rptr_n};
      end

      case (state)
        FILL:  if (wr_p) datW <= sw;
        WRITE: begin
          wptr <= wptr + 3'd1;
          if (wptr == 3'd7) full <= 1'b1;
        end
        SCAN:  if (mode_p) datW <= 4'd0;
        CLR: begin
          cptr <= cptr + 3'd1;
          if (cptr == 3'd7) begin
            wptr <= '0;
            rptr <= '0;
            full <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign addrW = (state == CLR) ? cptr : wptr;
  assign mode  = state;

endmodule

// File: tb/tb_bancoreg_loader.sv
// tb_bancoreg_loader
// Self-checking bench for bancoreg_loader with DB_CYCLES=4 and SCAN_CYCLES=8.
// Each expected bank write {addr, data} is queued when its button stimulus
// is driven. The monitor pops and compares an entry on every RegWrite cycle.
module tb_bancoreg_loader;

  localparam int DB = 4;
  localparam int SC = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] sw = 4'd0;
  logic       btn_wr = 1'b0;
  logic       btn_mode = 1'b0;
  logic [2:0] addrW, addrRa, addrRb;
  logic [3:0] datW;
  logic       RegWrite, full;
  logic [1:0] mode;

  bancoreg_loader #(.DB_CYCLES(DB), .SCAN_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn_wr(btn_wr), .btn_mode(btn_mode),
    .addrW(addrW), .datW(datW), .RegWrite(RegWrite),
    .addrRa(addrRa), .addrRb(addrRb), .mode(mode), .full(full)
  );

  // Clock and reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  int         checks = 0;
  int         errors = 0;
  logic [6:0] exp_q[$];
  int         wr_cnt = 0;
  int         wr_cyc = 0;
  bit         scan_seen = 1'b0;
  logic [2:0] m_wptr = 3'd0;
  bit         m_full = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      if (mode == 2'b10) scan_seen = 1'b1;
      if (RegWrite) begin
        wr_cnt++;
        wr_cyc = cyc;
        check("wr_expected", 32'(RegWrite), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0)
          check("wr_addr_data", 32'({addrW, datW}), 32'(exp_q.pop_front()));
      end
    end
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    btn_wr = 1'b0;
    btn_mode = 1'b0;
    tick(3);
    rst = 1'b1;
    m_wptr = 3'd0;
    m_full = 1'b0;
    tick(1);
  endtask

  task automatic press_wr(input logic [3:0] d);
    sw = d;
    btn_wr = 1'b1;
    exp_q.push_back({m_wptr, d});
    if (m_wptr == 3'd7) m_full = 1'b1;
    m_wptr = m_wptr + 3'd1;
    tick(10);
    btn_wr = 1'b0;
    tick(6);
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    tick(10);
    btn_mode = 1'b0;
    tick(6);
  endtask

  task automatic wait_mode(input logic [1:0] m, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (mode !== m && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(mode), 32'(m));
  endtask

  task automatic wait_we(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (RegWrite !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(RegWrite), 32'd1);
  endtask

  int n0;
  int rise;

  initial begin
    // Reset values
    tick(2);
    check("rst_mode",   32'(mode),     32'd0);
    check("rst_we",     32'(RegWrite), 32'd0);
    check("rst_addrw",  32'(addrW),    32'd0);
    check("rst_datw",   32'(datW),     32'd0);
    check("rst_ra",     32'(addrRa),   32'd0);
    check("rst_rb",     32'(addrRb),   32'd7);
    check("rst_full",   32'(full),     32'd0);
    rst = 1'b1;
    tick(2);

    // A 3-cycle glitch must not produce a write.
    n0 = wr_cnt;
    btn_wr = 1'b1;
    tick(3);
    btn_wr = 1'b0;
    tick(12);
    check("glitch_no_write", 32'(wr_cnt), 32'(n0));

    // A held press gives one write, 7 cycles after the rise.
    n0 = wr_cnt;
    sw = 4'hA;
    exp_q.push_back({m_wptr, 4'hA});
    m_wptr = m_wptr + 3'd1;
    rise = cyc;
    btn_wr = 1'b1;
    tick(20);
    btn_wr = 1'b0;
    tick(6);
    check("held_one_write", 32'(wr_cnt - n0), 32'd1);
    check("press_latency",  32'(wr_cyc - rise), 32'd7);

    // Eight writes, then a wrap back to address 0.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      press_wr(4'(15 - i));
      if (i == 6) check("full_before_8", 32'(full), 32'd0);
    end
    check("full_after_8", 32'(full), 32'd1);
    press_wr(4'd3);
    check("full_stays", 32'(full), 32'(m_full));

    // Scan sequence
    btn_mode = 1'b1;
    wait_mode(2'b10, "enter_scan");
    btn_mode = 1'b0;
    for (int p = 0; p < 5; p++) begin
      for (int c = 0; c < 8; c++) begin
        check("scan_ra", 32'(addrRa), 32'(p % 4));
        check("scan_rb", 32'(addrRb), 32'(7 - (p % 4)));
        @(negedge clk);
      end
    end
    n0 = wr_cnt;
    btn_wr = 1'b1;
    repeat (12) @(negedge clk);
    btn_wr = 1'b0;
    repeat (6) @(negedge clk);
    check("scan_ignores_wr", 32'(wr_cnt), 32'(n0));
    check("still_scan", 32'(mode), 32'd2);

    // Clear: eight consecutive zero writes to addresses 0..7.
    for (int i = 0; i < 8; i++) exp_q.push_back({3'(i), 4'h0});
    btn_mode = 1'b1;
    wait_we("clr_start");
    for (int i = 0; i < 8; i++) begin
      check("clr_we", 32'(RegWrite), 32'd1);
      @(negedge clk);
    end
    check("clr_end_we",   32'(RegWrite), 32'd0);
    check("clr_end_mode", 32'(mode),     32'd0);
    check("clr_end_full", 32'(full),     32'd0);
    btn_mode = 1'b0;
    m_wptr = 3'd0;
    m_full = 1'b0;
    tick(6);
    press_wr(4'd5);

    // Simultaneous presses: the write wins, and no scan follows.
    n0 = wr_cnt;
    scan_seen = 1'b0;
    sw = 4'd9;
    exp_q.push_back({m_wptr, 4'd9});
    m_wptr = m_wptr + 3'd1;
    btn_wr = 1'b1;
    btn_mode = 1'b1;
    tick(10);
    btn_wr = 1'b0;
    btn_mode = 1'b0;
    tick(10);
    check("simul_one_write", 32'(wr_cnt - n0), 32'd1);
    check("simul_mode",      32'(mode),        32'd0);
    check("simul_no_scan",   32'(scan_seen),   32'd0);

    // Reset in the middle of a clear.
    press_mode();
    check("pre_clr_scan", 32'(mode), 32'd2);
    for (int i = 0; i < 3; i++) exp_q.push_back({3'(i), 4'h0});
    btn_mode = 1'b1;
    wait_we("rclr_start");
    for (int i = 0; i < 3; i++) begin
      check("rclr_we", 32'(RegWrite), 32'd1);
      if (i < 2) @(negedge clk);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    btn_mode = 1'b0;
    #1;
    check("rclr_we_drop", 32'(RegWrite), 32'd0);
    check("rclr_mode",    32'(mode),     32'd0);
    tick(2);
    rst = 1'b1;
    m_wptr = 3'd0;
    m_full = 1'b0;
    tick(2);
    check("post_rst_mode",  32'(mode),  32'd0);
    check("post_rst_addrw", 32'(addrW), 32'd0);
    check("post_rst_full",  32'(full),  32'd0);
    press_wr(4'd6);

    tick(5);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bancoreg_loader.md
# bancoreg_loader

Write/read initiator for the `Bancoreg` register bank, so the board can run it without a testbench. It turns raw switch and push-button inputs into single-cycle bank write transactions with an auto-incrementing write address. It then scans read-address pairs for the bank's 7-segment display. It can also sequentially clear all eight registers to zero.

## Interface
- `DB_CYCLES`, default 250000: cycles a synchronized button must be stable high before it counts as a press.
- `SCAN_CYCLES`, default 50000000: dwell cycles per read-address pair in scan mode.
- `clk`  in  1: single system clock; all state on rising edge.
- `rst`  in  1: reset, asynchronous and active-low.
- `sw`  in  4: data switches, written as `datW`.
- `btn_wr`  in  1: raw write button, asynchronous and bouncy.
- `btn_mode`  in  1: raw mode button, asynchronous and bouncy.
- `addrW`  out  3: bank write address.
- `datW`  out  4: bank write data.
- `RegWrite`  out  1: bank write enable, registered.
- `addrRa`  out  3: bank read port A address.
- `addrRb`  out  3: bank read port B address.
- `mode`  out  2: current state; 00 FILL, 01 WRITE, 10 SCAN, 11 CLR.
- `full`  out  1: set when address 7 has been written since the last reset or clear.

## Operation
- **Button conditioning**, identical for each button:
  - 2-flop synchronizer feeds a stability counter.
  - Counter clears whenever the synchronized level is 0 and saturates at `DB_CYCLES`.
  - Debounced level is 1 while the counter equals `DB_CYCLES`.
  - A rising edge of the debounced level gives a one-cycle pulse, `wr_p` or `mode_p`.
  - Holding a button yields exactly one pulse.
- **FILL**, the reset state:
  - `RegWrite`=0 and `addrW`=`wptr`.
  - On `wr_p`: capture `sw` into `datW` and go to WRITE.
  - Else on `mode_p`: go to SCAN.
  - If both pulse in the same cycle, `wr_p` wins and `mode_p` is dropped.
- **WRITE**:
  - Lasts exactly one cycle with `RegWrite`=1, `addrW`=`wptr`, `datW` = captured value.
  - Then `wptr` ← `wptr`+1 modulo 8 (7 wraps to 0).
  - If `wptr` was 7, set `full`.
  - Return to FILL.
  - Pulses arriving during WRITE are dropped.
- **SCAN**:
  - `RegWrite`=0, `addrRa`=`rptr` (0..3), `addrRb`=7−`rptr`.
  - The dwell counter counts SCAN_CYCLES cycles, then `rptr` ← (`rptr`+1) mod 4 and the dwell counter restarts.
  - `wr_p` is ignored.
  - `mode_p` goes to CLR.
- **CLR**:
  - Runs 8 consecutive cycles with `RegWrite`=1, `datW`=0, `addrW`=`cptr`=0,1,…,7.
  - Then `wptr`=0, `rptr`=0, `cptr`=0, `full`=0, and return to FILL.
  - All pulses are ignored during CLR.
- **Read-address rules**:
  - Outside SCAN, `addrRa`/`addrRb` hold their last values.
  - On entry to SCAN from FILL, scanning resumes at the current `rptr`.

## Timing
- **Reset values** (asynchronous, while `rst`=0):
  - `mode`=00, `RegWrite`=0, `addrW`=0, `datW`=0, `addrRa`=0, `addrRb`=7, `full`=0.
  - `wptr`, `rptr`, `cptr`, dwell counter and debounce counters = 0.
  - Synchronizers = 0.
- **Reset mid-operation**, in WRITE, CLR or SCAN: immediate return to the reset state.
  - A partially completed clear is not resumed.
  - Registers already written in the bank keep their contents.
- **Press latency**: if the raw button is high from edge k, the pulse is high in cycle k+2+`DB_CYCLES`; WRITE (`RegWrite`=1) is the next cycle.
- **Write fields**: `RegWrite`, `addrW` and `datW` change only on clock edges and are stable for the whole asserted cycle.
- **Write count**: each WRITE produces exactly one bank write; each CLR produces exactly eight, on consecutive cycles.
- **Width rules**: `wptr`/`cptr` are 3-bit wrap, `rptr` is 2-bit wrap; `addrRb` is computed as 3'd7−{1'b0,`rptr`}.
- **Counter widths**: dwell and debounce counters are sized with `$clog2` of the parameter plus 1.

## Test plan
All scenarios use `DB_CYCLES`=4 and `SCAN_CYCLES`=8.
- **Reset and button filtering**: `rst`=0 then 1 → all outputs at reset values. A 3-cycle high glitch on `btn_wr` → no WRITE. A held `btn_wr` → exactly one `RegWrite` pulse, 7 cycles after the rise.
- **Eight writes and wrap**: eight presses with `sw`=15,14,…,8 → writes (addr,data) = (0,15)…(7,8). `full`=1 after the eighth. A ninth press with `sw`=3 writes (0,3).
- **Scan sequence**: press `btn_mode` → `mode`=10; (`addrRa`,`addrRb`) = (0,7),(1,6),(2,5),(3,4),(0,7), each held 8 cycles. Pressing `btn_wr` during scan → no `RegWrite`.
- **Clear**: second `btn_mode` press → 8 consecutive `RegWrite` cycles, addr 0..7, data 0. Then `mode`=00, `full`=0, next write goes to address 0.
- **Simultaneous pulses**: `btn_wr` and `btn_mode` rise on the same edge in FILL → one WRITE, `mode` returns to 00, no SCAN.
- **Reset mid-clear**: `rst` low after the third clear cycle → `RegWrite`=0 immediately. After release, `mode`=00 and `addrW`=0.
